// File: rtl/gate_delay_meter_pkg.sv
// rtl/gate_delay_meter_pkg.sv - shared types and constants for the gate delay meter
//
// Purpose: FSM state encoding and synchronizer depth shared by the top and
// the synchronizer sub-module.
package gate_delay_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer
//
// Purpose: bring an asynchronous level into the clk domain.
// Ports:
//   clk   - sampling clock, rising edge
//   rst_n - asynchronous active-low reset, clears every stage to 0
//   d     - asynchronous input level
//   q     - synchronized output level
module sync_2ff
  import gate_delay_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/gate_delay_meter.sv
// rtl/gate_delay_meter.sv - measures the propagation delay of an external gate
//
// Purpose: waits for the gate output to be quiet, toggles the gate input,
// then counts clk cycles until the synchronized gate output changes.
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - one-cycle request for one measurement (honoured in IDLE only)
//   dut_out   - asynchronous output of the gate under test
//   dut_in    - registered stimulus into the gate under test
//   busy      - high whenever the FSM is not in IDLE
//   done      - one-cycle pulse when a result is valid
//   timeout   - last measurement ran out of count
//   edge_rise - dut_in level launched by the last measurement
//   delay_cnt - measured delay in clk cycles, synchronizer latency included
module gate_delay_meter
  import gate_delay_meter_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int TIMEOUT    = 255,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic             dut_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             edge_rise,
  output logic [CNT_W-1:0] delay_cnt
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT);

  state_t           state;
  logic             sync_out;
  logic             prev_sync;
  logic             ref_level;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (sync_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dut_in     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      edge_rise  <= 1'b0;
      delay_cnt  <= '0;
      cnt        <= '0;
      settle_cnt <= '0;
      prev_sync  <= 1'b0;
      ref_level  <= 1'b0;
    end else begin
      // prev_sync tracks sync_out every cycle so the first SETTLE cycle
      // already has a valid previous value to compare against.
      prev_sync <= sync_out;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            timeout    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (sync_out == prev_sync) begin
            if (settle_cnt == SETTLE_LAST) begin
              // Launch: the gate output has been quiet long enough.
              ref_level <= sync_out;
              dut_in    <= ~dut_in;
              edge_rise <= ~dut_in;
              cnt       <= '0;
              state     <= MEASURE;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end else begin
            settle_cnt <= '0;
          end
        end
        MEASURE: begin
          // A detected edge wins over the timeout in the same cycle.
          if (sync_out != ref_level) begin
            delay_cnt <= cnt;
            timeout   <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (cnt == CNT_MAX) begin
            delay_cnt <= CNT_MAX;
            timeout   <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_delay_meter.sv
// tb/tb_gate_delay_meter.sv - self-checking bench for gate_delay_meter
module tb_gate_delay_meter;

  localparam int CNT_W = 8;
  localparam int TMO   = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             dut_out;
  logic             dut_in;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             edge_rise;
  logic [CNT_W-1:0] delay_cnt;

  // Gate models: inverters with transport delay, a constant, a driven toggle.
  logic       inv15 = 1'b1;
  logic       inv5  = 1'b1;
  logic       const_lvl = 1'b1;
  logic       tog = 1'b1;
  logic [1:0] mode = 2'd0;

  always @(dut_in) inv15 <= #15 ~dut_in;
  always @(dut_in) inv5  <= #5 ~dut_in;

  assign dut_out = (mode == 2'd0) ? inv15 :
                   (mode == 2'd1) ? inv5  :
                   (mode == 2'd2) ? const_lvl : tog;

  always #5 clk = ~clk;

  gate_delay_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TMO),
    .SETTLE_CYC (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dut_out   (dut_out),
    .dut_in    (dut_in),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .edge_rise (edge_rise),
    .delay_cnt (delay_cnt)
  );

  typedef struct {
    int dly;
    bit to;
    bit er;
    bit din;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   exp_din = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expectation for the next launched measurement; flips the stimulus level.
  task automatic push_exp(input int dly, input bit to);
    exp_t e;
    exp_din = ~exp_din;
    e.dly = dly;
    e.to  = to;
    e.er  = exp_din;
    e.din = exp_din;
    sb.push_back(e);
  endtask

  task automatic pop_and_compare(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_delay_cnt"}, delay_cnt, e.dly);
      check({tag, "_timeout"},   timeout,   e.to);
      check({tag, "_edge_rise"}, edge_rise, e.er);
      check({tag, "_dut_in"},    dut_in,    e.din);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic wait_launch(input string tag, input int budget);
    bit seen = 1'b0;
    logic old = dut_in;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (dut_in !== old) seen = 1'b1;
    end
    check({tag, "_launch_seen"}, seen, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_din = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dut_in"},    dut_in,    0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_timeout"},   timeout,   0);
    check({tag, "_edge_rise"}, edge_rise, 0);
    check({tag, "_delay_cnt"}, delay_cnt, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dones;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    do_reset();
    check_reset_outputs("reset");

    // 15 ns inverter, rising launch.
    mode = 2'd0;
    push_exp(3, 1'b0);
    pulse_start();
    check("a_busy", busy, 1);
    wait_done("a", 100);
    pop_and_compare("a");
    @(negedge clk);
    check("a_done_one_cycle", done, 0);
    check("a_idle_busy", busy, 0);

    // 5 ns inverter, two back-to-back measurements.
    do_reset();
    mode = 2'd1;
    push_exp(2, 1'b0);
    pulse_start();
    wait_done("b1", 100);
    pop_and_compare("b1");
    @(negedge clk);
    push_exp(2, 1'b0);
    pulse_start();
    wait_done("b2", 100);
    pop_and_compare("b2");

    // Constant gate output: timeout after exactly TMO+1 MEASURE cycles.
    do_reset();
    mode = 2'd2;
    push_exp(TMO, 1'b1);
    pulse_start();
    wait_launch("c", 50);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    check("c_done_seen", seen, 1);
    check("c_measure_cycles", n, TMO + 1);
    pop_and_compare("c");

    // Toggling gate output holds SETTLE; launch 7 cycles after it stops
    // (2 sync flops + previous-value compare + 4 stable cycles).
    @(negedge clk);
    tog = 1'b1;
    mode = 2'd3;
    pulse_start();
    check("d_timeout_cleared", timeout, 0);
    for (int i = 0; i < 10; i++) begin
      tog = ~tog;
      if (i < 9) repeat (2) @(negedge clk);
    end
    check("d_no_launch_while_toggling", dut_in, exp_din);
    push_exp(TMO, 1'b1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (dut_in !== edge_rise || dut_in === exp_din) seen = 1'b1;
    end
    check("d_launch_seen", seen, 1);
    check("d_launch_delay", n, 7);
    wait_done("d", 60);
    pop_and_compare("d");

    // Reset two cycles into MEASURE aborts without a done pulse.
    @(negedge clk);
    mode = 2'd0;
    pulse_start();
    wait_launch("e", 50);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_din = 1'b0;
    #1;
    check_reset_outputs("e_abort");
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (done) dones++;
    end
    check("e_no_done", dones, 0);
    check("e_idle_after_reset", busy, 0);
    push_exp(3, 1'b0);
    pulse_start();
    wait_done("e_after", 100);
    pop_and_compare("e_after");

    // start held high: restart one cycle after each done pulse.
    do_reset();
    mode = 2'd1;
    push_exp(2, 1'b0);
    push_exp(2, 1'b0);
    start = 1'b1;
    wait_done("f1", 100);
    pop_and_compare("f1");
    check("f_busy_in_done", busy, 1);
    @(negedge clk);
    check("f_idle_gap", busy, 0);
    @(negedge clk);
    check("f_restart", busy, 1);
    wait_done("f2", 100);
    start = 1'b0;
    pop_and_compare("f2");
    repeat (2) @(negedge clk);
    check("f_stays_idle", busy, 0);
    check("f_sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gate_delay_meter.md
GATE_DELAY_METER -- requirements
Module: gate_delay_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the cycle counter and of the result.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum MEASURE count before abort; TIMEOUT SHALL be at most 2^CNT_W-1.
REQ-003 The block SHALL have parameter SETTLE_CYC, default 4, giving the number of consecutive stable synchronized dut_out cycles required before launch.
REQ-004 Port clk SHALL be an input of width 1: the single clock, rising-edge active.
REQ-005 Port rst_n SHALL be an input of width 1: asynchronous, active-low reset.
REQ-006 Port start SHALL be an input of width 1: a one-cycle request to begin one measurement.
REQ-007 Port dut_out SHALL be an input of width 1: the asynchronous output of the delayed gate under test.
REQ-008 Port dut_in SHALL be an output of width 1: the registered stimulus driving the gate under test.
REQ-009 Port busy SHALL be an output of width 1, high in every state except IDLE.
REQ-010 Port done SHALL be an output of width 1: a one-cycle pulse when a result is valid.
REQ-011 Port timeout SHALL be an output of width 1, high when the last measurement hit TIMEOUT.
REQ-012 Port edge_rise SHALL be an output of width 1: the dut_in level launched in the last measurement.
REQ-013 Port delay_cnt SHALL be an output of width CNT_W: the measured delay in clk cycles, including synchronizer latency.

Function
REQ-014 dut_out SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value sync_out.
REQ-015 The FSM SHALL have exactly the states IDLE, SETTLE, MEASURE and DONE.
REQ-016 In IDLE, start=1 SHALL move the FSM to SETTLE with the settle counter cleared, and SHALL clear timeout.
REQ-017 In any state other than IDLE, start SHALL be ignored.
REQ-018 In SETTLE, the settle counter SHALL increment each cycle that sync_out equals its previous-cycle value, and SHALL reset to 0 on any change.
REQ-019 When the settle counter reaches SETTLE_CYC-1 with sync_out stable, the same edge SHALL:
  - capture sync_out as ref_level;
  - toggle dut_in and load the new dut_in value into edge_rise;
  - clear cnt to 0;
  - enter MEASURE.
REQ-020 SETTLE SHALL have no timeout; a permanently toggling dut_out holds the FSM in SETTLE until reset.
REQ-021 In MEASURE, each edge SHALL act as follows:
  - if sync_out != ref_level: delay_cnt<=cnt, timeout<=0, go to DONE;
  - else if cnt==TIMEOUT: delay_cnt<=TIMEOUT, timeout<=1, go to DONE;
  - else: cnt<=cnt+1.
REQ-022 The detection condition in REQ-021 SHALL take priority over the timeout condition in the same cycle.
REQ-023 cnt SHALL never wrap; it saturates at TIMEOUT by construction.
REQ-024 DONE SHALL last exactly one cycle, assert done, then return to IDLE.
REQ-025 delay_cnt, timeout and edge_rise SHALL hold their values until the next result or reset.
REQ-026 dut_in SHALL change only on the launch edge, so successive measurements alternate rising and falling stimuli.
REQ-027 start=1 in the DONE cycle SHALL be ignored; start=1 in the following IDLE cycle SHALL be accepted.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously set state=IDLE, dut_in=0, busy=0, done=0, timeout=0, edge_rise=0, delay_cnt=0, cnt=0, settle counter=0 and both synchronizer flops=0.
REQ-029 Reset asserted mid-SETTLE or mid-MEASURE SHALL abort the measurement with no done pulse.
REQ-030 After rst_n deasserts, the block SHALL wait in IDLE for a new start.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration (2-bit) and the constant SYNC_STAGES=2.
REQ-032 The synchronizer SHALL be the sub-module sync_2ff, a 1-bit, 2-flop synchronizer with async active-low reset to 0.
REQ-033 The rest of the block SHALL be a single FSM plus counters.

Verification (clk period 10 ns; DUT is an inverter with a transport delay)
REQ-034 Inverter delay 15 ns, start pulse after reset -> done pulse, delay_cnt=3, timeout=0, edge_rise=1, dut_in=1.
REQ-035 Inverter delay 5 ns, two back-to-back measurements -> delay_cnt=2 both times; edge_rise=1 then 0.
REQ-036 dut_out tied constant, TIMEOUT=20 -> done pulse with timeout=1 and delay_cnt=20, exactly 21 cycles after entering MEASURE.
REQ-037 dut_out toggling every 20 ns during SETTLE -> no launch while toggling; launch exactly SETTLE_CYC stable cycles after toggling stops.
REQ-038 rst_n pulled low 2 cycles into MEASURE -> all outputs at reset values, no done pulse; a new start then yields a normal result.
REQ-039 start held high continuously -> each measurement starts one cycle after the previous done pulse; start is ignored while busy=1.
